// File: rtl/sram_mem_ctrl.sv
// MEM-stage data-memory controller: splits each 32-bit load/store into two
// 16-bit SRAM accesses (low half, then high half) and stalls the pipeline via ready.
module sram_mem_ctrl #(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOW  = 2'd1;
    localparam logic [1:0] HIGH = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int          CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [31:0] BASE = 32'(BASE_ADDR);
    localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES - 1);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          is_write;
    logic [16:0]   word;
    logic [31:0]   data;
    logic          req;
    logic          last;
    logic [16:0]   req_word;

    assign req      = rd_en | wr_en;
    assign last     = (cnt == LAST_CNT);
    // Offset wraps modulo 2^32; only the low 17 bits of the word index reach the SRAM.
    assign req_word = 17'((address - BASE) >> 2);
    assign ready    = ~req | (state == DONE);

    // Request capture; a simultaneous read and write is performed as a write.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            is_write <= wr_en;
            word     <= req_word;
            data     <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            read_data   <= '0;
            sram_we_n   <= 1'b1;
            sram_dq_oe  <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state       <= LOW;
                        cnt         <= '0;
                        sram_addr   <= {req_word, 1'b0};
                        sram_we_n   <= ~wr_en;
                        sram_dq_oe  <= wr_en;
                        sram_dq_out <= write_data[15:0];
                    end
                end
                LOW: begin
                    if (last) begin
                        state       <= HIGH;
                        cnt         <= '0;
                        sram_addr   <= {word, 1'b1};
                        sram_dq_out <= data[31:16];
                        if (!is_write) read_data[15:0] <= sram_dq_in;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (last) begin
                        state      <= DONE;
                        cnt        <= '0;
                        sram_we_n  <= 1'b1;
                        sram_dq_oe <= 1'b0;
                        if (!is_write) read_data[31:16] <= sram_dq_in;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
